// File: rtl/llc_set_read_stage.sv
// llc_set_read_stage
// Takes decoded set/tag/kind packets from the LLC input decoder and issues
// the set read to the tag/state SRAM. The fixed-latency read data is
// re-joined with its packet and buffered for the lookup stage behind
// valid/ready. Credits (request reg + alignment pipe + buffer) are capped at
// DEPTH, so every issued read is guaranteed a buffer slot.
// Optional feature: define LLC_SET_READ_HAZARD_EN to block accepts that would
// read a set being written in the same cycle.
// Reset: rst is synchronous and active-low.
`timescale 1ns/1ps

module llc_set_read_stage #(
  parameter int SET_BITS = 8,
  parameter int TAG_BITS = 16,
  parameter int DATA_W   = 128,
  parameter int RD_LAT   = 2,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decode_push,
  input  logic [SET_BITS-1:0]       decode_set,
  input  logic [TAG_BITS-1:0]       decode_tag,
  input  logic [2:0]                decode_kind,
  output logic                      mem_full,
  output logic                      rd_set_en,
  output logic                      sram_rd_en,
  output logic [SET_BITS-1:0]       sram_rd_set,
  input  logic [DATA_W-1:0]         sram_rd_data,
  input  logic                      sram_wr_en,
  input  logic [SET_BITS-1:0]       sram_wr_set,
  output logic                      lookup_valid,
  input  logic                      lookup_ready,
  output logic [SET_BITS-1:0]       lookup_set,
  output logic [TAG_BITS-1:0]       lookup_tag,
  output logic [2:0]                lookup_kind,
  output logic [DATA_W-1:0]         lookup_data,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [SET_BITS-1:0] set;
    logic [TAG_BITS-1:0] tag;
    logic [2:0]          kind;
  } pkt_t;

  typedef struct packed {
    pkt_t              pkt;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              accept;
  logic              credit_full;
  logic              hazard;
  logic              req_valid;
  pkt_t              req_pkt;
  logic [RD_LAT-1:0] pipe_valid;
  pkt_t              pipe_pkt [RD_LAT];
  entry_t            fifo_mem [DEPTH];
  logic [OCC_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  fifo_count;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_full;
  entry_t            head;

  // Same-set read/write hazard blocks the accept combinationally.
`ifdef LLC_SET_READ_HAZARD_EN
  assign hazard = decode_push && sram_wr_en && (decode_set == sram_wr_set);
`else
  logic unused_wr;
  assign unused_wr = ^{sram_wr_en, sram_wr_set};
  assign hazard    = 1'b0;
`endif

  // Reserved credits: request reg + alignment pipe + buffered entries.
  // NOTE: every variable driven in always_comb gets a value before any
  // conditional logic, so no path leaves it unassigned and no latch appears.
  always_comb begin
    occupancy = fifo_count + OCC_W'(req_valid);
    for (int i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + OCC_W'(pipe_valid[i]);
    end
  end

  assign credit_full = (occupancy == OCC_W'(DEPTH));
  assign mem_full    = credit_full || hazard;
  assign rd_set_en   = !mem_full;
  assign accept      = decode_push && !mem_full;

  assign sram_rd_en  = req_valid;
  assign sram_rd_set = req_pkt.set;

  // Request register: capture an accepted packet, strobe the SRAM next cycle.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_valid <= 1'b0;
      req_pkt   <= '0;
    end else begin
      req_valid <= accept;
      if (accept) begin
        req_pkt <= '{set: decode_set, tag: decode_tag, kind: decode_kind};
      end
    end
  end

  // Alignment pipe valids: cleared on reset so late SRAM data is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= req_valid;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Alignment pipe payload: only meaningful under its valid, so no reset.
  always_ff @(posedge clk) begin
    pipe_pkt[0] <= req_pkt;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_pkt[i] <= pipe_pkt[i-1];
    end
  end

  assign fifo_wr      = pipe_valid[RD_LAT-1];
  assign fifo_count   = wr_ptr - rd_ptr;
  assign fifo_full    = (fifo_count == OCC_W'(DEPTH));
  assign lookup_valid = (fifo_count != '0);
  assign fifo_rd      = lookup_valid && lookup_ready;

  // Output buffer: circular pointers with a wrap bit; writes join pipe + data.
  // NOTE: the storage is reset because its head drives lookup_* directly and
  // those outputs must read zero after reset; with only DEPTH entries the
  // cost is small.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= '{pkt: pipe_pkt[RD_LAT-1], data: sram_rd_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head        = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign lookup_set  = head.pkt.set;
  assign lookup_tag  = head.pkt.tag;
  assign lookup_kind = head.pkt.kind;
  assign lookup_data = head.data;

endmodule

// File: tb/tb_llc_set_read_stage.sv
// Self-checking bench for llc_set_read_stage. A transaction-level model
// (list of accepted packets with their accept cycle) predicts credits,
// SRAM read strobes, lookup timing and contents; the bench also plays the
// SRAM, returning each packet's data RD_LAT cycles after its read.
`timescale 1ns/1ps

module tb_llc_set_read_stage;

  localparam int SET_BITS = 8;
  localparam int TAG_BITS = 16;
  localparam int DATA_W   = 128;
  localparam int RD_LAT   = 2;
  localparam int DEPTH    = 4;
  localparam int OCC_W    = $clog2(DEPTH) + 1;
  localparam int MAXP     = 4096;

  logic                clk = 1'b0;
  logic                rst;
  logic                decode_push;
  logic [SET_BITS-1:0] decode_set;
  logic [TAG_BITS-1:0] decode_tag;
  logic [2:0]          decode_kind;
  logic                mem_full;
  logic                rd_set_en;
  logic                sram_rd_en;
  logic [SET_BITS-1:0] sram_rd_set;
  logic [DATA_W-1:0]   sram_rd_data;
  logic                sram_wr_en;
  logic [SET_BITS-1:0] sram_wr_set;
  logic                lookup_valid;
  logic                lookup_ready;
  logic [SET_BITS-1:0] lookup_set;
  logic [TAG_BITS-1:0] lookup_tag;
  logic [2:0]          lookup_kind;
  logic [DATA_W-1:0]   lookup_data;
  logic [OCC_W-1:0]    occupancy;

  always #5 clk = ~clk;

  llc_set_read_stage #(
    .SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS), .DATA_W(DATA_W),
    .RD_LAT(RD_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .decode_push(decode_push), .decode_set(decode_set),
    .decode_tag(decode_tag), .decode_kind(decode_kind),
    .mem_full(mem_full), .rd_set_en(rd_set_en),
    .sram_rd_en(sram_rd_en), .sram_rd_set(sram_rd_set),
    .sram_rd_data(sram_rd_data),
    .sram_wr_en(sram_wr_en), .sram_wr_set(sram_wr_set),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_set(lookup_set), .lookup_tag(lookup_tag),
    .lookup_kind(lookup_kind), .lookup_data(lookup_data),
    .occupancy(occupancy)
  );

  // Reference model: every accepted packet, in order, with its accept cycle.
  logic [SET_BITS-1:0] m_set  [MAXP];
  logic [TAG_BITS-1:0] m_tag  [MAXP];
  logic [2:0]          m_kind [MAXP];
  logic [DATA_W-1:0]   m_data [MAXP];
  int                  m_cyc  [MAXP];
  int n_acc, n_pop, n_data, now;
  int checks, errors;
  logic [DATA_W-1:0] next_data;

  // DUT behaviour observed in the last step.
  logic              obs_acc, obs_full, obs_pop;
  logic [DATA_W-1:0] obs_data;

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: drive SRAM data, compare DUT against the model, advance.
  task automatic step();
    int   occ;
    logic exp_full, exp_rd_en, exp_valid, m_acc, m_pop;
    if (n_data < n_acc && m_cyc[n_data] + 1 + RD_LAT == now) begin
      sram_rd_data = m_data[n_data];
      n_data++;
    end else begin
      sram_rd_data = rand_word();
    end
    #1;
    occ      = n_acc - n_pop;
    exp_full = (occ == DEPTH);
`ifdef LLC_SET_READ_HAZARD_EN
    if (decode_push && sram_wr_en && decode_set == sram_wr_set) exp_full = 1'b1;
`endif
    exp_rd_en = (n_acc > 0) && (m_cyc[n_acc-1] == now - 1);
    exp_valid = (n_pop < n_acc) && (m_cyc[n_pop] + 2 + RD_LAT <= now);

    checks++;
    if (occupancy !== OCC_W'(occ)) begin
      errors++;
      $display("FAIL occupancy @%0d: got %0d expected %0d", now, occupancy, occ);
    end
    checks++;
    if (mem_full !== exp_full || rd_set_en !== !exp_full) begin
      errors++;
      $display("FAIL mem_full @%0d: got full=%b en=%b expected full=%b", now, mem_full, rd_set_en, exp_full);
    end
    checks++;
    if (sram_rd_en !== exp_rd_en) begin
      errors++;
      $display("FAIL sram_rd_en @%0d: got %b expected %b", now, sram_rd_en, exp_rd_en);
    end
    if (exp_rd_en) begin
      checks++;
      if (sram_rd_set !== m_set[n_acc-1]) begin
        errors++;
        $display("FAIL sram_rd_set @%0d: got %h expected %h", now, sram_rd_set, m_set[n_acc-1]);
      end
    end
    checks++;
    if (lookup_valid !== exp_valid) begin
      errors++;
      $display("FAIL lookup_valid @%0d: got %b expected %b", now, lookup_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (lookup_set !== m_set[n_pop] || lookup_tag !== m_tag[n_pop] ||
          lookup_kind !== m_kind[n_pop] || lookup_data !== m_data[n_pop]) begin
        errors++;
        $display("FAIL lookup_fields @%0d pkt %0d: got %h/%h/%0d/%h expected %h/%h/%0d/%h",
                 now, n_pop, lookup_set, lookup_tag, lookup_kind, lookup_data,
                 m_set[n_pop], m_tag[n_pop], m_kind[n_pop], m_data[n_pop]);
      end
    end
    if (dut.fifo_wr && dut.fifo_full) begin
      checks++;
      errors++;
      $display("FAIL fifo_overflow @%0d: write into full buffer got 1 expected 0", now);
    end

    obs_acc  = decode_push && rd_set_en;
    obs_full = mem_full;
    obs_pop  = lookup_valid && lookup_ready;
    obs_data = lookup_data;

    m_acc = rst && decode_push && !exp_full;
    m_pop = rst && exp_valid && lookup_ready;
    if (m_acc) begin
      m_set[n_acc]  = decode_set;
      m_tag[n_acc]  = decode_tag;
      m_kind[n_acc] = decode_kind;
      m_data[n_acc] = next_data;
      m_cyc[n_acc]  = now;
      n_acc++;
    end
    if (m_pop) n_pop++;
    if (!rst) begin
      n_pop  = n_acc;
      n_data = n_acc;
    end
    next_data = rand_word();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle_inputs();
    decode_push = 1'b0;
    sram_wr_en  = 1'b0;
  endtask

  task automatic rand_packet();
    decode_set  = SET_BITS'($urandom());
    decode_tag  = TAG_BITS'($urandom());
    decode_kind = 3'($urandom());
  endtask

  task automatic expect_reset_outputs(input string tag);
    checks++;
    if (mem_full !== 1'b0 || rd_set_en !== 1'b1 || sram_rd_en !== 1'b0 ||
        sram_rd_set !== '0 || lookup_valid !== 1'b0 || occupancy !== '0 ||
        lookup_set !== '0 || lookup_tag !== '0 || lookup_kind !== '0 ||
        lookup_data !== '0) begin
      errors++;
      $display("FAIL %s: got full=%b en=%b rd=%b rdset=%h lv=%b occ=%0d set=%h tag=%h kind=%0d data=%h expected 0/1/0/0/0/0/0/0/0/0",
               tag, mem_full, rd_set_en, sram_rd_en, sram_rd_set, lookup_valid,
               occupancy, lookup_set, lookup_tag, lookup_kind, lookup_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_reset_outputs("reset_values");
    rst = 1'b1;
  endtask

  task automatic test_single();
    int pops;
    logic [DATA_W-1:0] got;
    pops = 0;
    got  = '0;
    lookup_ready = 1'b1;
    decode_push  = 1'b1;
    decode_set   = 8'h12;
    decode_tag   = 16'h0abc;
    decode_kind  = 3'd1;
    next_data    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    step();
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got %b expected 1", obs_acc);
    end
    idle_inputs();
    repeat (4) begin
      step();
      if (obs_pop) begin
        pops++;
        got = obs_data;
      end
    end
    checks++;
    if (pops != 1 || got !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF) begin
      errors++;
      $display("FAIL single_pop: got %0d pops data %h expected 1 pop data dead_beef...", pops, got);
    end
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL single_occ_T5: got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_back_to_back();
    int acc, pops, cyc;
    logic saw_full;
    acc = 0; pops = 0; cyc = 0; saw_full = 1'b0;
    lookup_ready = 1'b1;
    while (acc < 8 && cyc < 64) begin
      decode_push = 1'b1;
      rand_packet();
      step();
      if (obs_acc) acc++;
      if (obs_pop) pops++;
      if (obs_full) saw_full = 1'b1;
      cyc++;
    end
    idle_inputs();
    repeat (12) begin
      step();
      if (obs_pop) pops++;
    end
    checks++;
    if (acc != 8 || pops != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts %0d pops expected 8/8", acc, pops);
    end
    checks++;
    if (saw_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full_toggle: got %b expected 1", saw_full);
    end
  endtask

  task automatic test_backpressure();
    int acc, pops, wait_cyc;
    acc = 0; pops = 0; wait_cyc = 0;
    lookup_ready = 1'b0;
    repeat (6) begin
      decode_push = 1'b1;
      rand_packet();
      step();
      if (obs_acc) acc++;
    end
    checks++;
    if (acc != 4 || obs_full !== 1'b1) begin
      errors++;
      $display("FAIL bp_accepts: got %0d accepts full=%b expected 4 full=1", acc, obs_full);
    end
    idle_inputs();
    while (lookup_valid !== 1'b1 && wait_cyc < 10) begin
      step();
      wait_cyc++;
    end
    lookup_ready = 1'b1;
    step();
    checks++;
    if (obs_pop !== 1'b1 || obs_full !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_pop: got pop=%b full=%b expected 1/1", obs_pop, obs_full);
    end
    pops = obs_pop ? 1 : 0;
    step();
    checks++;
    if (obs_full !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_falls: got %b expected 0", obs_full);
    end
    if (obs_pop) pops++;
    repeat (8) begin
      step();
      if (obs_pop) pops++;
    end
    checks++;
    if (pops != 4) begin
      errors++;
      $display("FAIL bp_drain: got %0d pops expected 4", pops);
    end
  endtask

  task automatic test_simultaneous();
    int acc, cyc;
    acc = 0; cyc = 0;
    lookup_ready = 1'b0;
    while (acc < 4 && cyc < 10) begin
      decode_push = 1'b1;
      rand_packet();
      step();
      if (obs_acc) acc++;
      cyc++;
    end
    idle_inputs();
    repeat (6) step();
    lookup_ready = 1'b1;
    decode_push  = 1'b1;
    rand_packet();
    step();
    checks++;
    if (obs_acc !== 1'b0 || obs_pop !== 1'b1) begin
      errors++;
      $display("FAIL simul_refuse: got acc=%b pop=%b expected 0/1", obs_acc, obs_pop);
    end
    step();
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL simul_next_accept: got %b expected 1", obs_acc);
    end
    idle_inputs();
    repeat (10) step();
  endtask

  task automatic test_hazard();
    lookup_ready = 1'b1;
    idle_inputs();
    repeat (8) step();
    decode_push = 1'b1;
    decode_set  = 8'h20;
    decode_tag  = 16'h1234;
    decode_kind = 3'd2;
    sram_wr_en  = 1'b1;
    sram_wr_set = 8'h20;
    step();
`ifdef LLC_SET_READ_HAZARD_EN
    checks++;
    if (obs_acc !== 1'b0 || obs_full !== 1'b1) begin
      errors++;
      $display("FAIL hazard_block: got acc=%b full=%b expected 0/1", obs_acc, obs_full);
    end
    sram_wr_en = 1'b0;
    step();
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL hazard_retry: got %b expected 1", obs_acc);
    end
`else
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL hazard_off_accept: got %b expected 1", obs_acc);
    end
`endif
    decode_set  = 8'h21;
    sram_wr_en  = 1'b1;
    sram_wr_set = 8'h20;
    step();
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL hazard_other_set: got %b expected 1", obs_acc);
    end
    idle_inputs();
    repeat (8) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      decode_push  = ($urandom_range(0, 3) != 0);
      decode_set   = SET_BITS'($urandom_range(0, 7));
      decode_tag   = TAG_BITS'($urandom());
      decode_kind  = 3'($urandom());
      sram_wr_en   = 1'($urandom_range(0, 1));
      sram_wr_set  = SET_BITS'($urandom_range(0, 7));
      lookup_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    lookup_ready = 1'b1;
    repeat (20) step();
  endtask

  task automatic test_reset_midflight();
    int valids, pops;
    valids = 0; pops = 0;
    lookup_ready = 1'b0;
    repeat (3) begin
      decode_push = 1'b1;
      rand_packet();
      step();
    end
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    expect_reset_outputs("midflight_reset_values");
    lookup_ready = 1'b1;
    repeat (8) begin
      step();
      if (lookup_valid === 1'b1) valids++;
    end
    checks++;
    if (valids != 0) begin
      errors++;
      $display("FAIL midflight_late_data: got %0d valid cycles expected 0", valids);
    end
    decode_push = 1'b1;
    rand_packet();
    step();
    idle_inputs();
    if (obs_pop) pops++;
    repeat (6) begin
      step();
      if (obs_pop) pops++;
    end
    checks++;
    if (pops != 1) begin
      errors++;
      $display("FAIL midflight_recover: got %0d pops expected 1", pops);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst          = 1'b0;
    decode_push  = 1'b0;
    decode_set   = '0;
    decode_tag   = '0;
    decode_kind  = '0;
    sram_rd_data = '0;
    sram_wr_en   = 1'b0;
    sram_wr_set  = '0;
    lookup_ready = 1'b0;
    n_acc = 0; n_pop = 0; n_data = 0; now = 0;
    checks = 0; errors = 0;
    next_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_hazard();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
